rf_sequencer: RTL
=================

# rf_sequencer

Multi-cycle controller for the processing unit's register file: accepts one instruction at a time through a valid/ready handshake and drives the file's read addresses, write address, write data and write enable. Contains the ALU (add, sub, and, or, xor, mov, load-immediate). Sits between the instruction source and the 2-read/1-write register file and is the only master of that file's ports. Fixed 4-cycle occupancy per instruction, so there are no read-after-write hazards.

## Interface
- N, 2, register address width (2**N registers)
- M, 4, data width
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction fields valid
- instr_ready  out  1  sequencer can accept an instruction
- op  in  3  opcode
- d_sel  in  N  destination register
- a_sel  in  N  operand A register
- b_sel  in  N  operand B register
- imm  in  M  immediate for LDI
- A_adr  out  N  register file read address A
- B_adr  out  N  register file read address B
- A_dat  in  M  register file read data A (combinational from A_adr)
- B_dat  in  M  register file read data B (combinational from B_adr)
- D_adr  out  N  register file write address
- D_dat  out  M  register file write data
- Write  out  1  register file write enable
- done  out  1  one-cycle pulse: instruction retiring
- z_flag  out  1  zero flag
- c_flag  out  1  carry/borrow flag

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV (result=A), 110 LDI (result=imm), 111 NOP.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch op/d_sel/a_sel/b_sel/imm into the instruction register and go to READ.
  - READ: A_adr=a_sel, B_adr=b_sel (latched); latch A_dat/B_dat into operand registers at the end of the cycle; go to EXEC.
  - EXEC: compute the result and carry from the operand registers; latch them into the result register; go to WB.
  - WB: D_adr=d_sel, D_dat=result, Write=1 (0 for NOP), done=1, flags update; go to IDLE.
- instr_ready=0 in READ, EXEC and WB. Input fields are ignored outside the accepting edge.
- Arithmetic is mod 2**M.
  - ADD: C = carry out of bit M-1.
  - SUB: A−B; C=1 if A<B (borrow).
  - AND, OR, XOR, MOV, LDI: C=0.
  - Z = (result==0).
- NOP: traverses all states with Write=0 and flags unchanged; done still pulses.
- A_adr, B_adr and D_adr hold their last values outside the states that use them.

## Timing
- Accept at edge E0 → READ in cycle 1, EXEC in cycle 2, WB in cycle 3. The write commits at edge E3. IDLE in cycle 4; earliest next accept at E4.
- Throughput: 1 instruction per 4 cycles. Latency from accept to write commit: 3 edges.
- A register written in WB is visible to the next instruction's READ with no stall.
- Reset values: state IDLE, instr_ready=0 while rst=1 (1 in the first cycle after release), Write=0, done=0, A_adr=B_adr=D_adr=0, D_dat=0, z_flag=0, c_flag=0.
- rst asserted in any state: the in-flight instruction is abandoned, no write occurs (including when rst is high during WB), and the FSM is in IDLE after the edge.
- instr_valid high while rst high: not accepted.

## Configuration
- SEQ_FLAGS_EN defined: z_flag/c_flag are registers updated in WB for every non-NOP opcode.
- SEQ_FLAGS_EN undefined: flag registers are not built and z_flag=c_flag=0 constantly.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then LDI R1=9, LDI R2=8, ADD R3=R1+R2 → each write at accept+3 edges; R3=0x1, c_flag=1, z_flag=0; done pulses once per instruction.
- SUB R0=R2−R1 (8−9) → R0=0xF, c_flag=1. Then SUB R0=R1−R1 → R0=0, z_flag=1, c_flag=0.
- NOP with instr_valid pulsed → Write stays 0 for all 4 cycles, done pulses in WB, flags keep prior values.
- instr_valid held high for 12 cycles with changing fields → exactly 3 accepts at E0, E4, E8; instr_ready low in the 3 cycles after each accept; each instruction uses the fields present at its own accept edge.
- ADD in flight, rst high during EXEC → Write never asserted, register file unchanged, flags 0, instr_ready=1 in the cycle after rst drops.
- Build without SEQ_FLAGS_EN and rerun the first scenario → identical register contents; z_flag=c_flag=0 throughout.

Source files
------------

// File: rtl/rf_sequencer_if.sv
// Instruction handshake plus register-file port bundle for rf_sequencer.
// Purely structural: no logic, no latency.
// Backpressure is carried by instr_ready; the register-file side is never stalled.
interface rf_sequencer_if #(
    parameter int N = 2,
    parameter int M = 4
);
    logic         instr_valid;
    logic         instr_ready;
    logic [2:0]   op;
    logic [N-1:0] d_sel;
    logic [N-1:0] a_sel;
    logic [N-1:0] b_sel;
    logic [M-1:0] imm;
    logic [N-1:0] A_adr;
    logic [N-1:0] B_adr;
    logic [M-1:0] A_dat;
    logic [M-1:0] B_dat;
    logic [N-1:0] D_adr;
    logic [M-1:0] D_dat;
    logic         Write;
    logic         done;
    logic         z_flag;
    logic         c_flag;

    // Sequencer side: consumes instructions and read data, drives the file.
    modport master (
        input  instr_valid, op, d_sel, a_sel, b_sel, imm, A_dat, B_dat,
        output instr_ready, A_adr, B_adr, D_adr, D_dat, Write, done, z_flag, c_flag
    );

    // Instruction source / register file side.
    modport slave (
        output instr_valid, op, d_sel, a_sel, b_sel, imm, A_dat, B_dat,
        input  instr_ready, A_adr, B_adr, D_adr, D_dat, Write, done, z_flag, c_flag
    );
endinterface

// File: rtl/rf_sequencer.sv
// Register-file sequencer with ALU: IDLE->READ->EXEC->WB, one instruction per 4 cycles.
// Latency: write commits 3 edges after the accept edge; done pulses in WB.
// Backpressure: instr_ready only in IDLE (and not in reset). SEQ_FLAGS_EN builds z/c flag registers.
module rf_sequencer #(
    parameter int N = 2,
    parameter int M = 4
) (
    input  logic          clk,
    input  logic          rst,
    rf_sequencer_if.master bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EXEC, ST_WB} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    state_t       state_q, state_d;
    logic [2:0]   op_q;
    logic [N-1:0] d_q;
    logic [M-1:0] imm_q;
    logic [N-1:0] a_adr_q, b_adr_q, d_adr_q;
    logic [M-1:0] a_q, b_q;
    logic [M-1:0] result_q;
    logic [M-1:0] alu_res;
    logic         alu_c;
    logic         ready_w, write_w, done_w;

    // State register; reset abandons whatever instruction is in flight.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state and strobes; strobes are masked by rst so a WB under reset never writes.
    always_comb begin
        state_d = state_q;
        ready_w = 1'b0;
        write_w = 1'b0;
        done_w  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_w = !rst;
                if (bus.instr_valid && !rst) state_d = ST_READ;
            end
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                done_w  = !rst;
                write_w = !rst && (op_q != OP_NOP);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU on the operand registers; carry doubles as borrow for SUB.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD:  {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  {alu_c, alu_res} = {1'b0, a_q} - {1'b0, b_q};
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_MOV:  alu_res = a_q;
            OP_LDI:  alu_res = imm_q;
            default: alu_res = '0;
        endcase
    end

    // Datapath: read addresses load at accept so they are valid throughout READ,
    // then hold; operands latch at end of READ, result and D_adr at end of EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            d_q      <= '0;
            imm_q    <= '0;
            a_adr_q  <= '0;
            b_adr_q  <= '0;
            d_adr_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            if (state_q == ST_IDLE && bus.instr_valid) begin
                op_q    <= bus.op;
                d_q     <= bus.d_sel;
                imm_q   <= bus.imm;
                a_adr_q <= bus.a_sel;
                b_adr_q <= bus.b_sel;
            end
            if (state_q == ST_READ) begin
                a_q <= bus.A_dat;
                b_q <= bus.B_dat;
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_res;
                d_adr_q  <= d_q;
            end
        end
    end

`ifdef SEQ_FLAGS_EN
    logic carry_q, z_q, c_q;

    // Carry is captured alongside the result; flags commit at the end of a non-NOP WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            if (state_q == ST_EXEC) carry_q <= alu_c;
            if (state_q == ST_WB && op_q != OP_NOP) begin
                z_q <= (result_q == '0);
                c_q <= carry_q;
            end
        end
    end

    assign bus.z_flag = z_q;
    assign bus.c_flag = c_q;
`else
    logic unused_alu_c;
    assign unused_alu_c = alu_c;
    assign bus.z_flag   = 1'b0;
    assign bus.c_flag   = 1'b0;
`endif

    assign bus.instr_ready = ready_w;
    assign bus.Write       = write_w;
    assign bus.done        = done_w;
    assign bus.A_adr       = a_adr_q;
    assign bus.B_adr       = b_adr_q;
    assign bus.D_adr       = d_adr_q;
    assign bus.D_dat       = result_q;
endmodule
